booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Self-contained sequential radix-2 Booth multiplier: controller FSM, accumulator, multiplier shift register and iteration counter in one block.
- Generalised over operand width N.
- Adds a per-operation signed/unsigned mode, a registered held product, a busy flag and defined abort-on-reset behaviour.
- Sits beside other arithmetic units; driven by a start/done handshake from a host sequencer.

Parameters:
- N, 16, operand width in bits (legal N >= 2); product is 2N bits.
- CW, $clog2(N+2), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- sgn  input  1  1 = operands are two's complement; 0 = operands are unsigned. Sampled with start.
- mcand  input  N  multiplicand, sampled with start.
- mplier  input  N  multiplier, sampled with start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse: product valid.
- product  output  2N  result, registered and held until the next done.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). When rst=1 at a rising edge:
  - state=IDLE;
  - busy=0, done=0, product=0;
  - internal A, Q, M, q_1 and count are cleared.
  - rst has priority over every other input.
- Internal width: X=N+1. Operands are extended to X bits at load.
  - sgn=1: sign-extended.
  - sgn=0: zero-extended.
  - This makes unsigned N-bit operands valid positive X-bit signed values.
- Registers:
  - A (X bits, accumulator);
  - Q (X bits, multiplier);
  - M (X bits, multiplicand);
  - q_1 (1 bit);
  - count (CW bits).
- States:
  - IDLE:
    - busy=0, done=0.
    - If start=1: load A=0, Q=ext(mplier), M=ext(mcand), q_1=0, count=X, then go to RUN.
    - Otherwise stay in IDLE.
  - RUN: busy=1. Each cycle performs one combined Booth step:
    - {Q[0],q_1}=01: A'=A+M.
    - {Q[0],q_1}=10: A'=A-M.
    - 00 or 11: A'=A.
    - Arithmetic right shift of {A',Q,q_1} by 1, with A' MSB replicated.
    - count decrements by 1.
    - A'+/-M is X-bit modular; the overflow carry is discarded.
    - When count=1 during a step, that step is the last. The same edge writes product = lower 2N bits of the shifted {A,Q} and moves to DONE.
  - DONE:
    - done=1, busy=0, for exactly one cycle.
    - Unconditionally returns to IDLE.
    - start seen in DONE is ignored and not queued.
- Latency: start=1 sampled at edge t leads to the last RUN step at edge t+X (= t+N+1). done is high in the cycle after that edge. A new start may be sampled at edge t+N+3 at the earliest.
- Busy window: start is ignored in RUN and DONE. Changes to mcand, mplier or sgn after the load edge have no effect.
- product:
  - Changes only on entry to DONE, or on reset.
  - Held through IDLE and through the following RUN.
- Result correctness:
  - sgn=1: product = signed(mcand) * signed(mplier), exact in 2N bits, including -2^(N-1) * -2^(N-1).
  - sgn=0: product = mcand * mplier, exact unsigned in 2N bits.
- Reset mid-RUN: aborts the operation. done is not asserted for it. product returns to 0.
- No outputs are combinationally dependent on inputs. busy and done decode the registered state only.

Test Plan:
- N=16, sgn=1, mcand=0xFFFD (-3), mplier=0x0005 -> busy high for 17 cycles; done pulses exactly 17 edges after start; product=0xFFFFFFF1.
- sgn=0, mcand=0xFFFF, mplier=0xFFFF -> product=0xFFFE0001. Also sgn=1 with the same operands -> product=0x00000001.
- sgn=1, mcand=0x8000, mplier=0x8000 -> product=0x40000000. Also sgn=1, 0x8000 * 0x0001 -> 0xFFFF8000.
- Back-to-back: start held high continuously with changing operands -> one operation per 19 cycles. Pulses arriving in RUN/DONE are ignored; each product matches the operands sampled at its own load edge. product is held between done pulses.
- Reset mid-operation: rst=1 for one edge at RUN cycle 8 -> busy=0, product=0, and no done pulse. A following start 7*9 (sgn=0) -> product=0x0000003F.
- Zero and identity: 0x0000 * 0x1234 -> 0; sgn=0 0x0001 * 0xABCD -> 0x0000ABCD. Re-run the whole suite at N=4 and N=32 against a reference model with random operands in both modes.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a start/done handshake.
// Signed and unsigned operands share one datapath by extending them one bit wider at load.
module booth_mult_seq #(
    parameter int N  = 16,
    parameter int CW = $clog2(N + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [N-1:0]     mcand,
    input  logic [N-1:0]     mplier,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int X = N + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [X-1:0]     acc_q, acc_d;
    logic [X-1:0]     mul_q, mul_d;
    logic [X-1:0]     mcd_q, mcd_d;
    logic             qPrev_q, qPrev_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [X-1:0]     extMcand;
    logic [X-1:0]     extMplier;
    logic [X-1:0]     sum;
    logic [2*X-1:0]   shifted;

    // One extra bit makes unsigned operands positive signed values.
    assign extMcand  = {sgn & mcand[N-1], mcand};
    assign extMplier = {sgn & mplier[N-1], mplier};

    always_comb begin
        sum = acc_q;
        case ({mul_q[0], qPrev_q})
            2'b01:   sum = acc_q + mcd_q;
            2'b10:   sum = acc_q - mcd_q;
            default: sum = acc_q;
        endcase
        shifted = {sum[X-1], sum, mul_q[X-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mul_d     = mul_q;
        mcd_d     = mcd_q;
        qPrev_d   = qPrev_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mul_d   = extMplier;
                    mcd_d   = extMcand;
                    qPrev_d = 1'b0;
                    count_d = CW'(X);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = shifted[2*X-1:X];
                mul_d   = shifted[X-1:0];
                qPrev_d = mul_q[0];
                count_d = count_q - CW'(1);
                // The final step also captures the product on the same edge.
                if (count_q == CW'(1)) begin
                    product_d = shifted[2*N-1:0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mul_q     <= '0;
            mcd_q     <= '0;
            qPrev_q   <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mul_q     <= mul_d;
            mcd_q     <= mcd_d;
            qPrev_q   <= qPrev_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at N=16, with extra N=4 and N=32 instances
// exercised by random operands against a 64-bit reference multiply.
module tb_booth_mult_seq;

    logic         clk;
    logic         rst;

    logic         start, sgn;
    logic [15:0]  mcand, mplier;
    logic         busy, done;
    logic [31:0]  product;

    logic         start4, sgn4;
    logic [3:0]   mcand4, mplier4;
    logic         busy4, done4;
    logic [7:0]   product4;

    logic         start32, sgn32;
    logic [31:0]  mcand32, mplier32;
    logic         busy32, done32;
    logic [63:0]  product32;

    logic [63:0]  scoreboard[$];
    int           checks;
    int           passes;

    booth_mult_seq #(.N(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn),
        .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .product(product)
    );

    booth_mult_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sgn(sgn4),
        .mcand(mcand4), .mplier(mplier4),
        .busy(busy4), .done(done4), .product(product4)
    );

    booth_mult_seq #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sgn(sgn32),
        .mcand(mcand32), .mplier(mplier32),
        .busy(busy32), .done(done32), .product(product32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend both operands to 64 bits, multiply, keep 2n bits.
    function automatic logic [63:0] refMul(input int n, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, pmask, ea, eb;
        mask = (64'd1 << n) - 64'd1;
        ea = {32'd0, a} & mask;
        eb = {32'd0, b} & mask;
        if (s && a[n-1]) ea = ea | ~mask;
        if (s && b[n-1]) eb = eb | ~mask;
        pmask = (2 * n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * n)) - 64'd1);
        return (ea * eb) & pmask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse on the N=16 unit and records the expected product.
    task automatic applyStimulus(input logic s, input logic [15:0] a, input logic [15:0] b,
                                 input logic [63:0] expv);
        sgn    = s;
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        scoreboard.push_back(expv);
        tick();
        start  = 1'b0;
        sgn    = ~s;
        mcand  = 16'($urandom);
        mplier = 16'($urandom);
    endtask

    task automatic runOp(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [63:0] expv, output logic [63:0] got,
                         output logic [63:0] expOut, output int edges, output int busyCnt);
        applyStimulus(s, a, b, expv);
        edges   = 0;
        busyCnt = busy ? 1 : 0;
        while (!done && edges < 100) begin
            tick();
            edges++;
            if (busy) busyCnt++;
        end
        got    = {32'd0, product};
        expOut = (scoreboard.size() > 0) ? scoreboard.pop_front() : 64'hx;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        sgn = 1'b1;
        mcand = 16'h1234;
        mplier = 16'h5678;
        tick();
        tick();
        checks++;
        if ({busy, done} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {busy, done});
        else passes++;
        checks++;
        if (product !== 32'h0) $display("[TB] FAIL reset_product: got %h expected 00000000", product);
        else passes++;
        checks++;
        if (product4 !== 8'h0 || product32 !== 64'h0)
            $display("[TB] FAIL reset_product_other: got %h/%h expected 0/0", product4, product32);
        else passes++;
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
        else passes++;
    endtask

    task automatic test_signed_basic();
        logic [63:0] got, expv;
        int edges, busyCnt;
        runOp(1'b1, 16'hFFFD, 16'h0005, 64'hFFFF_FFF1, got, expv, edges, busyCnt);
        checks++;
        if (got !== expv) $display("[TB] FAIL signed_basic: got %h expected %h", got, expv);
        else passes++;
        checks++;
        if (edges != 17) $display("[TB] FAIL done_latency: got %0d expected 17", edges);
        else passes++;
        checks++;
        if (busyCnt != 17) $display("[TB] FAIL busy_cycles: got %0d expected 17", busyCnt);
        else passes++;
        checks++;
        if ({busy, done} !== 2'b00) $display("[TB] FAIL done_pulse_width: got %b expected 00", {busy, done});
        else passes++;
        checks++;
        if (product !== 32'hFFFF_FFF1) $display("[TB] FAIL product_held_idle: got %h expected fffffff1", product);
        else passes++;
    endtask

    task automatic test_extremes();
        logic [63:0] got, expv;
        int edges, busyCnt;
        logic        ts[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] ta[4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000};
        logic [15:0] tb[4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0001};
        logic [31:0] te[4] = '{32'hFFFE_0001, 32'h0000_0001, 32'h4000_0000, 32'hFFFF_8000};
        for (int i = 0; i < 4; i++) begin
            runOp(ts[i], ta[i], tb[i], {32'd0, te[i]}, got, expv, edges, busyCnt);
            checks++;
            if (got !== expv || edges != 17)
                $display("[TB] FAIL extremes_%0d: got %h after %0d edges expected %h after 17", i, got, edges, expv);
            else passes++;
        end
    endtask

    task automatic test_zero_identity();
        logic [63:0] got, expv;
        int edges, busyCnt;
        logic        ts[3] = '{1'b1, 1'b0, 1'b0};
        logic [15:0] ta[3] = '{16'h0000, 16'h0000, 16'h0001};
        logic [15:0] tb[3] = '{16'h1234, 16'h1234, 16'hABCD};
        logic [31:0] te[3] = '{32'h0, 32'h0, 32'h0000_ABCD};
        for (int i = 0; i < 3; i++) begin
            runOp(ts[i], ta[i], tb[i], {32'd0, te[i]}, got, expv, edges, busyCnt);
            checks++;
            if (got !== expv || edges != 17)
                $display("[TB] FAIL zero_identity_%0d: got %h after %0d edges expected %h after 17", i, got, edges, expv);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] got, expv;
        int edges, busyCnt, doneSeen;
        applyStimulus(1'b1, 16'h1234, 16'h0567, 64'hx);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        scoreboard.delete();
        checks++;
        if ({busy, done} !== 2'b00 || product !== 32'h0)
            $display("[TB] FAIL abort_state: got busy/done %b product %h expected 00 and 00000000", {busy, done}, product);
        else passes++;
        doneSeen = 0;
        repeat (30) begin
            tick();
            if (done) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneSeen);
        else passes++;
        runOp(1'b0, 16'd7, 16'd9, 64'h3F, got, expv, edges, busyCnt);
        checks++;
        if (got !== expv || edges != 17)
            $display("[TB] FAIL after_abort: got %h after %0d edges expected %h after 17", got, edges, expv);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int doneCnt, cyc, lastDone, heldErr;
        logic [63:0] lastProd, expv;
        logic prevBusy, ps;
        logic [15:0] pa, pb;
        doneCnt = 0; cyc = 0; lastDone = -1; heldErr = 0;
        lastProd = '0;
        sgn = 1'($urandom); mcand = 16'($urandom); mplier = 16'($urandom);
        start = 1'b1;
        prevBusy = busy;
        while (doneCnt < 4 && cyc < 200) begin
            ps = sgn; pa = mcand; pb = mplier;
            tick();
            cyc++;
            if (busy && !prevBusy) scoreboard.push_back(refMul(16, ps, {16'd0, pa}, {16'd0, pb}));
            if (done) begin
                expv = (scoreboard.size() > 0) ? scoreboard.pop_front() : 64'hx;
                checks++;
                if ({32'd0, product} !== expv) $display("[TB] FAIL b2b_product_%0d: got %h expected %h", doneCnt, product, expv);
                else passes++;
                if (lastDone >= 0) begin
                    checks++;
                    if (cyc - lastDone != 19) $display("[TB] FAIL b2b_period_%0d: got %0d expected 19", doneCnt, cyc - lastDone);
                    else passes++;
                end
                lastDone = cyc;
                lastProd = {32'd0, product};
                doneCnt++;
                if (doneCnt == 4) start = 1'b0;
            end else if (lastDone >= 0 && {32'd0, product} !== lastProd) begin
                heldErr++;
            end
            prevBusy = busy;
            sgn = 1'($urandom); mcand = 16'($urandom); mplier = 16'($urandom);
        end
        start = 1'b0;
        tick();
        checks++;
        if (doneCnt != 4) $display("[TB] FAIL b2b_timeout: got %0d done pulses expected 4", doneCnt);
        else passes++;
        checks++;
        if (heldErr != 0) $display("[TB] FAIL b2b_product_held: got %0d changes expected 0", heldErr);
        else passes++;
        checks++;
        if (busy !== 1'b0 || scoreboard.size() != 0)
            $display("[TB] FAIL b2b_drain: got busy %b queue %0d expected 0 and 0", busy, scoreboard.size());
        else passes++;
    endtask

    task automatic test_random_n16();
        logic [63:0] got, expv;
        int edges, busyCnt;
        logic s;
        logic [15:0] a, b;
        for (int i = 0; i < 12; i++) begin
            s = 1'(i % 2);
            a = 16'($urandom);
            b = 16'($urandom);
            runOp(s, a, b, refMul(16, s, {16'd0, a}, {16'd0, b}), got, expv, edges, busyCnt);
            checks++;
            if (got !== expv || edges != 17)
                $display("[TB] FAIL rand16_%0d: got %h after %0d edges expected %h after 17", i, got, edges, expv);
            else passes++;
        end
    endtask

    task automatic test_random_n4();
        logic [63:0] expv;
        logic s;
        logic [3:0] a, b;
        int edges;
        for (int i = 0; i < 20; i++) begin
            s = 1'(i % 2);
            a = 4'($urandom);
            b = 4'($urandom);
            if (i == 0) begin s = 1'b0; a = 4'hF; b = 4'hF; end
            if (i == 1) begin s = 1'b1; a = 4'h8; b = 4'h8; end
            if (i == 0) scoreboard.push_back(64'hE1);
            else if (i == 1) scoreboard.push_back(64'h40);
            else scoreboard.push_back(refMul(4, s, {28'd0, a}, {28'd0, b}));
            sgn4 = s; mcand4 = a; mplier4 = b; start4 = 1'b1;
            tick();
            start4 = 1'b0;
            edges = 0;
            while (!done4 && edges < 50) begin
                tick();
                edges++;
            end
            expv = (scoreboard.size() > 0) ? scoreboard.pop_front() : 64'hx;
            checks++;
            if ({56'd0, product4} !== expv || edges != 5)
                $display("[TB] FAIL rand4_%0d: got %h after %0d edges expected %h after 5", i, product4, edges, expv);
            else passes++;
            tick();
        end
    endtask

    task automatic test_random_n32();
        logic [63:0] expv;
        logic s;
        logic [31:0] a, b;
        int edges;
        for (int i = 0; i < 12; i++) begin
            s = 1'(i % 2);
            a = $urandom;
            b = $urandom;
            if (i == 0) begin s = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            if (i == 1) begin s = 1'b1; a = 32'h8000_0000; b = 32'h8000_0000; end
            if (i == 0) scoreboard.push_back(64'hFFFF_FFFE_0000_0001);
            else if (i == 1) scoreboard.push_back(64'h4000_0000_0000_0000);
            else scoreboard.push_back(refMul(32, s, a, b));
            sgn32 = s; mcand32 = a; mplier32 = b; start32 = 1'b1;
            tick();
            start32 = 1'b0;
            edges = 0;
            while (!done32 && edges < 100) begin
                tick();
                edges++;
            end
            expv = (scoreboard.size() > 0) ? scoreboard.pop_front() : 64'hx;
            checks++;
            if (product32 !== expv || edges != 33)
                $display("[TB] FAIL rand32_%0d: got %h after %0d edges expected %h after 33", i, product32, edges, expv);
            else passes++;
            tick();
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        start = 1'b0; sgn = 1'b0; mcand = '0; mplier = '0;
        start4 = 1'b0; sgn4 = 1'b0; mcand4 = '0; mplier4 = '0;
        start32 = 1'b0; sgn32 = 1'b0; mcand32 = '0; mplier32 = '0;
        test_reset();
        test_signed_basic();
        test_extremes();
        test_zero_identity();
        test_reset_mid_run();
        test_back_to_back();
        test_random_n16();
        test_random_n4();
        test_random_n32();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
